calc_controller: RTL and testbench
==================================

CALC_CONTROLLER -- requirements
Module: calc_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter MULT_TIMEOUT, default 64, max cycles to wait for mult_done.
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have ports in_valid in 1 and in_ready out 1, the command handshake.
REQ-006 SHALL have port funct  in  3  opcode: 000 ADD, 001 SUB, 010 MULT, 100 ADDToPrev, 101 SUBToPrev, 110 MULTWithPrev; 011 and 111 illegal.
REQ-007 SHALL have ports operand_a and operand_b  in  WIDTH  signed two's-complement operands.
REQ-008 SHALL have ports mult_start out 1 (one-cycle pulse), mult_a out WIDTH, mult_b out WIDTH, mult_done in 1, mult_result in WIDTH (low WIDTH bits of the product) to the external multiplier.
REQ-009 SHALL have ports res_valid out 1 and res_ready in 1, the result handshake.
REQ-010 SHALL have ports result out WIDTH, prev out WIDTH (stored previous result), overflow out 1, error out 1.

Function
REQ-011 SHALL implement FSM states IDLE, MULT_WAIT, DONE; in_ready = 1 only in IDLE and not in reset.
REQ-012 SHALL accept a command when in_valid & in_ready, capturing funct, operand_a, operand_b.
REQ-013 SHALL use prev in place of operand_a for ADDToPrev, SUBToPrev, MULTWithPrev; operand_a ignored.
REQ-014 ADD/SUB (incl. ToPrev): SHALL register result = A+B or A-B modulo 2^WIDTH in the accept cycle and enter DONE; res_valid high the following cycle (latency 1).
REQ-015 ADD/SUB: overflow SHALL be 1 iff signed overflow occurred (operand signs per op, result sign differs).
REQ-016 MULT/MULTWithPrev: SHALL drive mult_a/mult_b from the captured operands, pulse mult_start for exactly one cycle (the cycle after accept), enter MULT_WAIT, and clear a wait counter.
REQ-017 MULT_WAIT: on mult_done = 1, SHALL register result = mult_result, overflow = 0, error = 0, enter DONE.
REQ-018 MULT_WAIT: if MULT_TIMEOUT cycles elapse after mult_start with no mult_done, SHALL set result = 0, error = 1, enter DONE; prev unchanged.
REQ-019 Illegal funct: SHALL set result = 0, error = 1, overflow = 0, enter DONE in the accept cycle; prev unchanged; no mult_start.
REQ-020 Every legal, non-timed-out op SHALL write its result into prev on the same edge result is registered.
REQ-021 DONE: res_valid = 1; result, overflow, error held stable until res_ready = 1; on res_valid & res_ready SHALL return to IDLE (next command accepted one cycle later).
REQ-022 mult_done outside MULT_WAIT, including a late done after timeout, SHALL be ignored.
REQ-023 mult_done in the same cycle the counter hits MULT_TIMEOUT SHALL be treated as success.
REQ-024 overflow and error SHALL reflect only the most recent completed command.

Reset
REQ-025 With reset = 1 at a clk edge: state = IDLE, prev = 0, result = 0, overflow = 0, error = 0, res_valid = 0, mult_start = 0, mult_a = mult_b = 0, counter = 0; in_ready = 0 while reset is high.
REQ-026 Reset SHALL override any state mid-operation; an in-flight multiply is abandoned, no further mult_start issued, subsequent mult_done ignored.

Verification
REQ-027 WIDTH=8: ADD a=0x70 b=0x20 -> res_valid next cycle, result=0x90, overflow=1, prev=0x90.
REQ-028 Following REQ-027, SUBToPrev b=0x10 with res_ready held 0 for 3 cycles -> result=0x80 held stable, overflow=0, in_ready=0 until handshake, prev=0x80.
REQ-029 MULT a=3 b=5, mult_done asserted 4 cycles after mult_start with mult_result=15 -> mult_start one-cycle pulse, result=15, error=0, prev=15.
REQ-030 MULT_TIMEOUT=8, MULTWithPrev with mult_done never asserted -> error=1, result=0 after 8 wait cycles, prev unchanged; late mult_done ignored.
REQ-031 funct=011 -> error=1, result=0, no mult_start, prev unchanged; then ADD 1+1 -> result=2, error=0.
REQ-032 Reset asserted in MULT_WAIT -> all outputs per REQ-025 next cycle, prev=0, in_ready=1 cycle after reset drops.

Source files
------------

// File: rtl/calc_controller.sv
// Command-driven ALU controller: ADD/SUB computed in-line, MULT delegated to an
// external multiplier with a bounded wait; results handed off via valid/ready.
module calc_controller #(
  parameter int WIDTH        = 32,
  parameter int MULT_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       funct,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic             mult_start,
  output logic [WIDTH-1:0] mult_a,
  output logic [WIDTH-1:0] mult_b,
  input  logic             mult_done,
  input  logic [WIDTH-1:0] mult_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] prev,
  output logic             overflow,
  output logic             error
);

  // state     | meaning
  // IDLE      | ready for a command
  // MULT_WAIT | multiply launched, waiting for mult_done or timeout
  // DONE      | result presented, waiting for res_ready
  typedef enum logic [1:0] {S_IDLE, S_MULT_WAIT, S_DONE} state_t;

  localparam int CW = $clog2(MULT_TIMEOUT + 1);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_result, r_prev, r_mult_a, r_mult_b;
  logic             r_overflow, r_error, r_mult_start;

  logic             w_accept, w_illegal, w_is_mult, w_timeout, w_wait_end;
  logic             w_add_ovf, w_sub_ovf;
  logic [WIDTH-1:0] w_op_a, w_sum, w_diff;

  assign w_accept   = in_valid && in_ready;
  assign w_illegal  = (funct[1:0] == 2'b11);
  assign w_is_mult  = (funct[1:0] == 2'b10);
  assign w_op_a     = funct[2] ? r_prev : operand_a;
  assign w_sum      = w_op_a + operand_b;
  assign w_diff     = w_op_a - operand_b;
  assign w_add_ovf  = (w_op_a[WIDTH-1] == operand_b[WIDTH-1]) && (w_sum[WIDTH-1]  != w_op_a[WIDTH-1]);
  assign w_sub_ovf  = (w_op_a[WIDTH-1] != operand_b[WIDTH-1]) && (w_diff[WIDTH-1] != w_op_a[WIDTH-1]);
  // A done arriving on the timeout cycle still wins.
  assign w_timeout  = (r_cnt == CW'(MULT_TIMEOUT)) && !mult_done;
  assign w_wait_end = mult_done || w_timeout;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_accept) w_state_nxt = w_is_mult ? S_MULT_WAIT : S_DONE;
      S_MULT_WAIT: if (w_wait_end) w_state_nxt = S_DONE;
      S_DONE:      if (res_ready) w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_result     <= '0;
      r_prev       <= '0;
      r_overflow   <= 1'b0;
      r_error      <= 1'b0;
      r_mult_start <= 1'b0;
      r_mult_a     <= '0;
      r_mult_b     <= '0;
    end else begin
      r_mult_start <= 1'b0;
      if (r_state == S_IDLE && w_accept) begin
        if (w_illegal) begin
          r_result   <= '0;
          r_overflow <= 1'b0;
          r_error    <= 1'b1;
        end else if (w_is_mult) begin
          r_mult_a     <= w_op_a;
          r_mult_b     <= operand_b;
          r_mult_start <= 1'b1;
          r_cnt        <= '0;
        end else begin
          r_result   <= funct[0] ? w_diff : w_sum;
          r_prev     <= funct[0] ? w_diff : w_sum;
          r_overflow <= funct[0] ? w_sub_ovf : w_add_ovf;
          r_error    <= 1'b0;
        end
      end else if (r_state == S_MULT_WAIT) begin
        if (mult_done) begin
          r_result   <= mult_result;
          r_prev     <= mult_result;
          r_overflow <= 1'b0;
          r_error    <= 1'b0;
        end else if (w_timeout) begin
          r_result   <= '0;
          r_overflow <= 1'b0;
          r_error    <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign in_ready   = (r_state == S_IDLE) && !reset;
  assign res_valid  = (r_state == S_DONE);
  assign result     = r_result;
  assign prev       = r_prev;
  assign overflow   = r_overflow;
  assign error      = r_error;
  assign mult_start = r_mult_start;
  assign mult_a     = r_mult_a;
  assign mult_b     = r_mult_b;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: a vector table for single-cycle ops plus
// hand sequences for multiply latency, timeout, boundary-done and mid-op reset.
module tb_calc_controller;
  localparam int W  = 8;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_ready, mult_start, mult_done;
  logic         res_valid, res_ready, overflow, error;
  logic [2:0]   funct;
  logic [W-1:0] operand_a, operand_b, mult_a, mult_b, mult_result, result, prev;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  calc_controller #(.WIDTH(W), .MULT_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .operand_a(operand_a), .operand_b(operand_b),
    .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
    .mult_done(mult_done), .mult_result(mult_result),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .prev(prev), .overflow(overflow), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (mult_start) n_starts++;

  typedef struct {
    logic [2:0]   f;
    logic [W-1:0] a, b, res, prv;
    logic         ovf, err;
    int           hold;
  } vec_t;

  vec_t vt[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int i;
    funct = f; operand_a = a; operand_b = b; in_valid = 1'b1;
    i = 0;
    while (!in_ready && i < 20) begin tick(); i++; end
    if (i == 20) chk("in_ready_wait", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);
    chk("idle_res_valid", 32'(res_valid), 32'd0);
  endtask

  // Caller sits in the mult_start cycle; done_at < 0 means never raise mult_done.
  task automatic wait_res(input int done_at, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 40) begin
      if (cyc == done_at) mult_done = 1'b1;
      tick();
      mult_done = 1'b0;
      cyc++;
    end
  endtask

  initial begin
    int base, cyc;
    vt[0] = '{3'b000, 8'h70, 8'h20, 8'h90, 8'h90, 1'b1, 1'b0, 0};
    vt[1] = '{3'b101, 8'h00, 8'h10, 8'h80, 8'h80, 1'b0, 1'b0, 3};
    vt[2] = '{3'b001, 8'h80, 8'h01, 8'h7F, 8'h7F, 1'b1, 1'b0, 0};
    vt[3] = '{3'b100, 8'h33, 8'h01, 8'h80, 8'h80, 1'b1, 1'b0, 1};
    vt[4] = '{3'b011, 8'h01, 8'h02, 8'h00, 8'h80, 1'b0, 1'b1, 0};
    vt[5] = '{3'b000, 8'h01, 8'h01, 8'h02, 8'h02, 1'b0, 1'b0, 0};
    vt[6] = '{3'b111, 8'h05, 8'h05, 8'h00, 8'h02, 1'b0, 1'b1, 0};
    vt[7] = '{3'b001, 8'h05, 8'h07, 8'hFE, 8'hFE, 1'b0, 1'b0, 0};
    vt[8] = '{3'b000, 8'hFF, 8'hFF, 8'hFE, 8'hFE, 1'b0, 1'b0, 0};
    vt[9] = '{3'b000, 8'h80, 8'h80, 8'h00, 8'h00, 1'b1, 1'b0, 0};

    reset = 1'b1; in_valid = 1'b0; funct = '0; operand_a = '0; operand_b = '0;
    mult_done = 1'b0; mult_result = '0; res_ready = 1'b0;
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_prev", 32'(prev), 32'd0);
    chk("rst_mult_start", 32'(mult_start), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 10; i++) begin
      send(vt[i].f, vt[i].a, vt[i].b);
      chk($sformatf("v%0d_res_valid", i), 32'(res_valid), 32'd1);
      chk($sformatf("v%0d_result", i), 32'(result), 32'(vt[i].res));
      chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'(vt[i].ovf));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(vt[i].err));
      chk($sformatf("v%0d_prev", i), 32'(prev), 32'(vt[i].prv));
      for (int h = 0; h < vt[i].hold; h++) begin
        tick();
        chk($sformatf("v%0d_hold_result", i), 32'(result), 32'(vt[i].res));
        chk($sformatf("v%0d_hold_in_ready", i), 32'(in_ready), 32'd0);
        chk($sformatf("v%0d_hold_res_valid", i), 32'(res_valid), 32'd1);
      end
      handshake();
    end
    chk("table_no_mult_start", 32'(n_starts), 32'd0);

    // MULT 3*5 with done four cycles after the start pulse
    send(3'b010, 8'd3, 8'd5);
    base = n_starts;
    chk("mul_start", 32'(mult_start), 32'd1);
    chk("mul_a", 32'(mult_a), 32'd3);
    chk("mul_b", 32'(mult_b), 32'd5);
    chk("mul_res_valid_early", 32'(res_valid), 32'd0);
    mult_result = 8'd15;
    wait_res(4, cyc);
    chk("mul_latency", 32'(cyc), 32'd5);
    chk("mul_result", 32'(result), 32'd15);
    chk("mul_overflow", 32'(overflow), 32'd0);
    chk("mul_error", 32'(error), 32'd0);
    chk("mul_prev", 32'(prev), 32'd15);
    chk("mul_one_pulse", 32'(n_starts - base), 32'd1);
    handshake();

    // MULTWithPrev that times out; late done must be ignored
    send(3'b110, 8'h55, 8'h03);
    chk("tmo_mult_a_prev", 32'(mult_a), 32'h0F);
    chk("tmo_mult_b", 32'(mult_b), 32'h03);
    mult_result = 8'h77;
    wait_res(-1, cyc);
    chk("tmo_cycles", 32'(cyc), 32'(TO + 1));
    chk("tmo_result", 32'(result), 32'd0);
    chk("tmo_error", 32'(error), 32'd1);
    chk("tmo_overflow", 32'(overflow), 32'd0);
    chk("tmo_prev", 32'(prev), 32'h0F);
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    chk("late_done_result", 32'(result), 32'd0);
    chk("late_done_error", 32'(error), 32'd1);
    chk("late_done_prev", 32'(prev), 32'h0F);
    handshake();
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    chk("idle_done_res_valid", 32'(res_valid), 32'd0);
    chk("idle_done_prev", 32'(prev), 32'h0F);

    // done arriving exactly on the timeout cycle counts as success
    send(3'b010, 8'd2, 8'd2);
    mult_result = 8'd4;
    wait_res(TO, cyc);
    chk("edge_cycles", 32'(cyc), 32'(TO + 1));
    chk("edge_result", 32'(result), 32'd4);
    chk("edge_error", 32'(error), 32'd0);
    chk("edge_prev", 32'(prev), 32'd4);
    handshake();

    // reset while in MULT_WAIT
    send(3'b010, 8'd7, 8'd9);
    base = n_starts;
    tick(); tick();
    reset = 1'b1;
    tick();
    chk("mrst_in_ready", 32'(in_ready), 32'd0);
    chk("mrst_res_valid", 32'(res_valid), 32'd0);
    chk("mrst_result", 32'(result), 32'd0);
    chk("mrst_prev", 32'(prev), 32'd0);
    chk("mrst_mult_ab", 32'({mult_a, mult_b}), 32'd0);
    chk("mrst_flags", 32'({mult_start, overflow, error}), 32'd0);
    reset = 1'b0;
    #1;
    chk("mrst_in_ready_after", 32'(in_ready), 32'd1);
    mult_done = 1'b1; mult_result = 8'h3F;
    tick();
    mult_done = 1'b0;
    chk("mrst_done_ignored", 32'(res_valid), 32'd0);
    chk("mrst_prev_after", 32'(prev), 32'd0);
    chk("mrst_no_restart", 32'(n_starts - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
